// File: rtl/instruction_sequencer_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: decode one-hot indices,
// FSM states, trap causes and PC / writeback mux codes.
package instruction_sequencer_pkg;

  localparam int unsigned ONEHOT_WIDTH           = 11;
  localparam int unsigned ONEHOT_LUI_INDEX       = 0;
  localparam int unsigned ONEHOT_AUIPC_INDEX     = 1;
  localparam int unsigned ONEHOT_JAL_INDEX       = 2;
  localparam int unsigned ONEHOT_JALR_INDEX      = 3;
  localparam int unsigned ONEHOT_BRANCH_INDEX    = 4;
  localparam int unsigned ONEHOT_LOAD_INDEX      = 5;
  localparam int unsigned ONEHOT_STORE_INDEX     = 6;
  localparam int unsigned ONEHOT_ITYPE_ALU_INDEX = 7;
  localparam int unsigned ONEHOT_RTYPE_ALU_INDEX = 8;
  localparam int unsigned ONEHOT_FENCE_INDEX     = 9;
  localparam int unsigned ONEHOT_DEBUG_INDEX     = 10;

  typedef enum logic [3:0] {
    SEQ_STATE_FETCH_REQ  = 4'd0,
    SEQ_STATE_FETCH_WAIT = 4'd1,
    SEQ_STATE_DECODE     = 4'd2,
    SEQ_STATE_EXECUTE    = 4'd3,
    SEQ_STATE_MEM_REQ    = 4'd4,
    SEQ_STATE_MEM_WAIT   = 4'd5,
    SEQ_STATE_WRITEBACK  = 4'd6,
    SEQ_STATE_TRAP       = 4'd7,
    SEQ_STATE_HALT       = 4'd8
  } seq_state_e;

  typedef enum logic [1:0] {
    TRAP_CAUSE_NONE        = 2'd0,
    TRAP_CAUSE_ILLEGAL     = 2'd1,
    TRAP_CAUSE_BUS_TIMEOUT = 2'd2
  } trap_cause_e;

  localparam logic [1:0] PC_SELECT_PLUS4   = 2'd0;
  localparam logic [1:0] PC_SELECT_PC_IMM  = 2'd1;
  localparam logic [1:0] PC_SELECT_RS1_IMM = 2'd2;

  localparam logic [1:0] WB_SELECT_ALU     = 2'd0;
  localparam logic [1:0] WB_SELECT_LOAD    = 2'd1;
  localparam logic [1:0] WB_SELECT_PC_PLUS4 = 2'd2;

  // Loads accept funct3 0,1,2,4,5; stores accept 0..2.
  function automatic logic is_illegal_encoding(input logic [ONEHOT_WIDTH-1:0] sel,
                                               input logic                    err,
                                               input logic [2:0]              funct3);
    logic bad_load;
    logic bad_store;
    bad_load  = sel[ONEHOT_LOAD_INDEX] &&
                ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
    bad_store = sel[ONEHOT_STORE_INDEX] && (funct3 > 3'd2);
    return err || bad_load || bad_store;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Instruction- and data-memory valid/ready handshake bundle.
interface instruction_sequencer_if;
  logic imem_req_valid;
  logic imem_req_ready;
  logic imem_resp_valid;
  logic dmem_req_valid;
  logic dmem_req_write;
  logic dmem_req_ready;
  logic dmem_resp_valid;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    input  imem_resp_valid,
    output dmem_req_valid,
    output dmem_req_write,
    input  dmem_req_ready,
    input  dmem_resp_valid
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    output imem_resp_valid,
    input  dmem_req_valid,
    input  dmem_req_write,
    output dmem_req_ready,
    output dmem_resp_valid
  );
endinterface

// File: rtl/sequencer_wait_timer.sv
// Bus wait counter: counts enabled cycles, flags the LIMIT-th cycle as expired.
module sequencer_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned COUNT_WIDTH = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(LIMIT - 1);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Counter value k means this is the (k+1)-th wait cycle.
  assign expired = (count == LAST);

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback,
// with illegal-instruction / bus-timeout traps and a debug halt.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned RETIRE_COUNT_WIDTH = 32,
  parameter int unsigned BUS_TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_sequencer_if.master       bus,
  output logic                          instruction_latch_en,
  input  logic [ONEHOT_WIDTH-1:0]       opcode_selection,
  input  logic                          decoding_error,
  input  logic [2:0]                    subfunction_3,
  input  logic [4:0]                    destination_reg,
  input  logic                          branch_condition,
  output logic                          pc_write_en,
  output logic [1:0]                    pc_select,
  output logic                          reg_write_en,
  output logic [1:0]                    writeback_select,
  output logic [RETIRE_COUNT_WIDTH-1:0] retired_count,
  output logic                          trap,
  output logic [1:0]                    trap_cause,
  output logic                          halted
);

  seq_state_e                    state;
  seq_state_e                    next_state;
  logic [ONEHOT_WIDTH-1:0]       class_q;
  logic [4:0]                    rd_q;
  logic                          branch_taken_q;
  trap_cause_e                   cause_q;
  logic [RETIRE_COUNT_WIDTH-1:0] retired_q;

  logic timer_enable;
  logic timer_clear;
  logic timer_expired;

  assign timer_enable = (state == SEQ_STATE_FETCH_REQ) || (state == SEQ_STATE_FETCH_WAIT) ||
                        (state == SEQ_STATE_MEM_REQ)   || (state == SEQ_STATE_MEM_WAIT);
  assign timer_clear  = (next_state != state);

  sequencer_wait_timer #(
    .LIMIT (BUS_TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SEQ_STATE_FETCH_REQ;
      class_q        <= '0;
      rd_q           <= '0;
      branch_taken_q <= 1'b0;
      cause_q        <= TRAP_CAUSE_NONE;
      retired_q      <= '0;
    end else begin
      state <= next_state;
      if (state == SEQ_STATE_DECODE) begin
        class_q <= opcode_selection;
        rd_q    <= destination_reg;
      end
      if (state == SEQ_STATE_EXECUTE) begin
        branch_taken_q <= branch_condition;
      end
      // Only DECODE traps for encoding; every other trap entry is a wait-state timeout.
      if ((next_state == SEQ_STATE_TRAP) && (state != SEQ_STATE_TRAP)) begin
        cause_q <= (state == SEQ_STATE_DECODE) ? TRAP_CAUSE_ILLEGAL : TRAP_CAUSE_BUS_TIMEOUT;
      end
      if (state == SEQ_STATE_WRITEBACK) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  always_comb begin
    next_state           = state;
    bus.imem_req_valid   = 1'b0;
    bus.dmem_req_valid   = 1'b0;
    bus.dmem_req_write   = 1'b0;
    instruction_latch_en = 1'b0;
    pc_write_en          = 1'b0;
    pc_select            = PC_SELECT_PLUS4;
    reg_write_en         = 1'b0;
    writeback_select     = WB_SELECT_ALU;

    case (state)
      SEQ_STATE_FETCH_REQ: begin
        bus.imem_req_valid = 1'b1;
        if (bus.imem_req_ready)  next_state = SEQ_STATE_FETCH_WAIT;
        else if (timer_expired)  next_state = SEQ_STATE_TRAP;
      end
      SEQ_STATE_FETCH_WAIT: begin
        if (bus.imem_resp_valid) next_state = SEQ_STATE_DECODE;
        else if (timer_expired)  next_state = SEQ_STATE_TRAP;
      end
      SEQ_STATE_DECODE: begin
        instruction_latch_en = 1'b1;
        if (is_illegal_encoding(opcode_selection, decoding_error, subfunction_3))
          next_state = SEQ_STATE_TRAP;
        else if (opcode_selection[ONEHOT_DEBUG_INDEX])
          next_state = SEQ_STATE_HALT;
        else
          next_state = SEQ_STATE_EXECUTE;
      end
      SEQ_STATE_EXECUTE: begin
        if (class_q[ONEHOT_LOAD_INDEX] || class_q[ONEHOT_STORE_INDEX])
          next_state = SEQ_STATE_MEM_REQ;
        else
          next_state = SEQ_STATE_WRITEBACK;
      end
      SEQ_STATE_MEM_REQ: begin
        bus.dmem_req_valid = 1'b1;
        bus.dmem_req_write = class_q[ONEHOT_STORE_INDEX];
        if (bus.dmem_req_ready)  next_state = SEQ_STATE_MEM_WAIT;
        else if (timer_expired)  next_state = SEQ_STATE_TRAP;
      end
      SEQ_STATE_MEM_WAIT: begin
        if (bus.dmem_resp_valid) next_state = SEQ_STATE_WRITEBACK;
        else if (timer_expired)  next_state = SEQ_STATE_TRAP;
      end
      SEQ_STATE_WRITEBACK: begin
        pc_write_en = 1'b1;
        if (class_q[ONEHOT_JAL_INDEX])
          pc_select = PC_SELECT_PC_IMM;
        else if (class_q[ONEHOT_JALR_INDEX])
          pc_select = PC_SELECT_RS1_IMM;
        else if (class_q[ONEHOT_BRANCH_INDEX] && branch_taken_q)
          pc_select = PC_SELECT_PC_IMM;
        reg_write_en = (rd_q != 5'd0) &&
                       (class_q[ONEHOT_LUI_INDEX]  || class_q[ONEHOT_AUIPC_INDEX] ||
                        class_q[ONEHOT_JAL_INDEX]  || class_q[ONEHOT_JALR_INDEX]  ||
                        class_q[ONEHOT_LOAD_INDEX] || class_q[ONEHOT_ITYPE_ALU_INDEX] ||
                        class_q[ONEHOT_RTYPE_ALU_INDEX]);
        if (class_q[ONEHOT_LOAD_INDEX])
          writeback_select = WB_SELECT_LOAD;
        else if (class_q[ONEHOT_JAL_INDEX] || class_q[ONEHOT_JALR_INDEX])
          writeback_select = WB_SELECT_PC_PLUS4;
        next_state = SEQ_STATE_FETCH_REQ;
      end
      SEQ_STATE_TRAP: next_state = SEQ_STATE_TRAP;
      SEQ_STATE_HALT: next_state = SEQ_STATE_HALT;
      default:        next_state = SEQ_STATE_FETCH_REQ;
    endcase
  end

  assign retired_count = retired_q;
  assign trap          = (state == SEQ_STATE_TRAP);
  assign trap_cause    = cause_q;
  assign halted        = (state == SEQ_STATE_HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer: the bench plays memory and decoder,
// and predicts each instruction's handshakes, outcome and writeback controls.
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned RCW     = 4;
  localparam int unsigned RMOD    = 16;

  localparam int OUT_RETIRED = 0;
  localparam int OUT_ILLEGAL = 1;
  localparam int OUT_HALT    = 2;
  localparam int OUT_TIMEOUT = 3;
  localparam int OUT_RESET   = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    instruction_latch_en;
  logic [ONEHOT_WIDTH-1:0] opcode_selection;
  logic                    decoding_error;
  logic [2:0]              subfunction_3;
  logic [4:0]              destination_reg;
  logic                    branch_condition;
  logic                    pc_write_en;
  logic [1:0]              pc_select;
  logic                    reg_write_en;
  logic [1:0]              writeback_select;
  logic [RCW-1:0]          retired_count;
  logic                    trap;
  logic [1:0]              trap_cause;
  logic                    halted;

  instruction_sequencer_if bus();

  instruction_sequencer #(
    .RETIRE_COUNT_WIDTH (RCW),
    .BUS_TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .instruction_latch_en (instruction_latch_en),
    .opcode_selection     (opcode_selection),
    .decoding_error       (decoding_error),
    .subfunction_3        (subfunction_3),
    .destination_reg      (destination_reg),
    .branch_condition     (branch_condition),
    .pc_write_en          (pc_write_en),
    .pc_select            (pc_select),
    .reg_write_en         (reg_write_en),
    .writeback_select     (writeback_select),
    .retired_count        (retired_count),
    .trap                 (trap),
    .trap_cause           (trap_cause),
    .halted               (halted)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_retired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference rules, by instruction class.
  function automatic bit exp_illegal(input int cls, input logic [2:0] f3, input bit err);
    if (err) return 1'b1;
    if (cls == ONEHOT_LOAD_INDEX && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (cls == ONEHOT_STORE_INDEX && f3 > 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_pc_select(input int cls, input bit taken);
    if (cls == ONEHOT_JAL_INDEX)    return 2'd1;
    if (cls == ONEHOT_JALR_INDEX)   return 2'd2;
    if (cls == ONEHOT_BRANCH_INDEX) return taken ? 2'd1 : 2'd0;
    return 2'd0;
  endfunction

  function automatic bit exp_reg_write(input int cls, input logic [4:0] rd);
    bit writes;
    writes = (cls == ONEHOT_LUI_INDEX) || (cls == ONEHOT_AUIPC_INDEX) ||
             (cls == ONEHOT_JAL_INDEX) || (cls == ONEHOT_JALR_INDEX) ||
             (cls == ONEHOT_LOAD_INDEX) || (cls == ONEHOT_ITYPE_ALU_INDEX) ||
             (cls == ONEHOT_RTYPE_ALU_INDEX);
    return writes && (rd != 5'd0);
  endfunction

  function automatic logic [1:0] exp_wb_select(input int cls);
    if (cls == ONEHOT_LOAD_INDEX) return 2'd1;
    if (cls == ONEHOT_JAL_INDEX || cls == ONEHOT_JALR_INDEX) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pc_we"}, 32'(pc_write_en), 0);
    check({tag, "_reg_we"}, 32'(reg_write_en), 0);
    check({tag, "_dmem_valid"}, 32'(bus.dmem_req_valid), 0);
    check({tag, "_retired"}, 32'(retired_count), exp_retired);
  endtask

  task automatic do_reset();
    reset                = 1'b1;
    bus.imem_req_ready   = 1'b0;
    bus.imem_resp_valid  = 1'b0;
    bus.dmem_req_ready   = 1'b0;
    bus.dmem_resp_valid  = 1'b0;
    opcode_selection     = '0;
    decoding_error       = 1'b0;
    subfunction_3        = '0;
    destination_reg      = '0;
    branch_condition     = 1'b0;
    next_cycle();
    next_cycle();
    reset       = 1'b0;
    exp_retired = 0;
    check("rst_trap", 32'(trap), 0);
    check("rst_cause", 32'(trap_cause), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_latch", 32'(instruction_latch_en), 0);
    check("rst_imem_valid", 32'(bus.imem_req_valid), 1);
    check_idle_outputs("rst");
  endtask

  task automatic check_absorbing(input string tag, input bit exp_trap, input logic [1:0] cause,
                                 input bit exp_halt, input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      check({tag, "_trap"}, 32'(trap), 32'(exp_trap));
      check({tag, "_cause"}, 32'(trap_cause), 32'(cause));
      check({tag, "_halted"}, 32'(halted), 32'(exp_halt));
      check({tag, "_imem_valid"}, 32'(bus.imem_req_valid), 0);
      check_idle_outputs(tag);
      bus.imem_req_ready  = 1'($urandom);
      bus.imem_resp_valid = 1'($urandom);
      bus.dmem_req_ready  = 1'($urandom);
      bus.dmem_resp_valid = 1'($urandom);
      next_cycle();
    end
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
  endtask

  // Waits: cycles of the request/wait state before the accepting cycle;
  // a wait of TIMEOUT or more means the accept never arrives in time.
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic [4:0] rd,
                           input bit err, input bit taken,
                           input int unsigned fetch_wait, input int unsigned resp_wait,
                           input int unsigned mem_wait, input int unsigned mresp_wait,
                           input bit reset_in_mem_wait, output int outcome);
    for (int unsigned c = 0; c <= fetch_wait; c++) begin
      if (c == TIMEOUT) begin
        check_absorbing("fetch_timeout", 1'b1, 2'd2, 1'b0, 3);
        outcome = OUT_TIMEOUT;
        return;
      end
      check("fetch_valid", 32'(bus.imem_req_valid), 1);
      check("fetch_trap", 32'(trap), 0);
      check_idle_outputs("fetch");
      bus.imem_req_ready = (c == fetch_wait);
      next_cycle();
    end
    bus.imem_req_ready = 1'b0;

    for (int unsigned c = 0; c <= resp_wait; c++) begin
      if (c == TIMEOUT) begin
        check_absorbing("resp_timeout", 1'b1, 2'd2, 1'b0, 3);
        outcome = OUT_TIMEOUT;
        return;
      end
      check("fwait_imem_valid", 32'(bus.imem_req_valid), 0);
      check("fwait_latch", 32'(instruction_latch_en), 0);
      check_idle_outputs("fwait");
      bus.imem_resp_valid = (c == resp_wait);
      next_cycle();
    end
    bus.imem_resp_valid = 1'b0;

    check("decode_latch", 32'(instruction_latch_en), 1);
    check_idle_outputs("decode");
    opcode_selection = ONEHOT_WIDTH'(1) << cls;
    subfunction_3    = f3;
    destination_reg  = rd;
    decoding_error   = err;
    next_cycle();
    // Scramble decode inputs so later stages must rely on latched fields.
    opcode_selection = ONEHOT_WIDTH'($urandom);
    subfunction_3    = 3'($urandom);
    destination_reg  = 5'($urandom);
    decoding_error   = 1'($urandom);

    if (exp_illegal(cls, f3, err)) begin
      check_absorbing("illegal", 1'b1, 2'd1, 1'b0, 20);
      outcome = OUT_ILLEGAL;
      return;
    end
    if (cls == ONEHOT_DEBUG_INDEX) begin
      check_absorbing("halt", 1'b0, 2'd0, 1'b1, 6);
      outcome = OUT_HALT;
      return;
    end

    check("exec_latch", 32'(instruction_latch_en), 0);
    check_idle_outputs("exec");
    branch_condition = taken;
    next_cycle();
    branch_condition = ~taken;

    if (cls == ONEHOT_LOAD_INDEX || cls == ONEHOT_STORE_INDEX) begin
      for (int unsigned c = 0; c <= mem_wait; c++) begin
        if (c == TIMEOUT) begin
          check_absorbing("mem_timeout", 1'b1, 2'd2, 1'b0, 3);
          outcome = OUT_TIMEOUT;
          return;
        end
        check("mreq_valid", 32'(bus.dmem_req_valid), 1);
        check("mreq_write", 32'(bus.dmem_req_write), 32'(cls == ONEHOT_STORE_INDEX));
        check("mreq_pc_we", 32'(pc_write_en), 0);
        bus.dmem_req_ready = (c == mem_wait);
        next_cycle();
      end
      bus.dmem_req_ready = 1'b0;

      for (int unsigned c = 0; c <= mresp_wait; c++) begin
        if (c == TIMEOUT) begin
          check_absorbing("mresp_timeout", 1'b1, 2'd2, 1'b0, 3);
          outcome = OUT_TIMEOUT;
          return;
        end
        check_idle_outputs("mwait");
        if (reset_in_mem_wait) begin
          reset = 1'b1;
          next_cycle();
          reset       = 1'b0;
          exp_retired = 0;
          check("mrst_imem_valid", 32'(bus.imem_req_valid), 1);
          check("mrst_trap", 32'(trap), 0);
          check("mrst_latch", 32'(instruction_latch_en), 0);
          check_idle_outputs("mrst");
          bus.dmem_resp_valid = 1'b1;
          next_cycle();
          bus.dmem_resp_valid = 1'b0;
          check("late_resp_imem_valid", 32'(bus.imem_req_valid), 1);
          check("late_resp_latch", 32'(instruction_latch_en), 0);
          check_idle_outputs("late_resp");
          outcome = OUT_RESET;
          return;
        end
        bus.dmem_resp_valid = (c == mresp_wait);
        next_cycle();
      end
      bus.dmem_resp_valid = 1'b0;
    end

    check("wb_pc_we", 32'(pc_write_en), 1);
    check("wb_pc_select", 32'(pc_select), 32'(exp_pc_select(cls, taken)));
    check("wb_reg_we", 32'(reg_write_en), 32'(exp_reg_write(cls, rd)));
    check("wb_select", 32'(writeback_select), 32'(exp_wb_select(cls)));
    check("wb_dmem_valid", 32'(bus.dmem_req_valid), 0);
    next_cycle();
    exp_retired = (exp_retired + 1) % RMOD;
    outcome = OUT_RETIRED;
  endtask

  function automatic logic [2:0] legal_f3(input int cls);
    logic [2:0] load_ok [5];
    load_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (cls == ONEHOT_LOAD_INDEX)  return load_ok[$urandom_range(0, 4)];
    if (cls == ONEHOT_STORE_INDEX) return 3'($urandom_range(0, 2));
    return 3'($urandom);
  endfunction

  initial begin
    int          outcome;
    int          cls;
    bit          err;
    int unsigned fw, rw, mw, mrw;

    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // ADDI rd=5 with zero-wait memory.
    run_instr(ONEHOT_ITYPE_ALU_INDEX, 3'd0, 5'd5, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, outcome);
    check("addi_outcome", 32'(outcome), OUT_RETIRED);
    // Taken then not-taken branch.
    run_instr(ONEHOT_BRANCH_INDEX, 3'd0, 5'd9, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, outcome);
    run_instr(ONEHOT_BRANCH_INDEX, 3'd0, 5'd9, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0, outcome);
    check("branch_retired", 32'(retired_count), 3);
    // LW with ready delayed 3 cycles, response 2 cycles later; SW variant.
    run_instr(ONEHOT_LOAD_INDEX, 3'd2, 5'd7, 1'b0, 1'b0, 0, 0, 3, 1, 1'b0, outcome);
    run_instr(ONEHOT_STORE_INDEX, 3'd2, 5'd7, 1'b0, 1'b0, 0, 0, 3, 1, 1'b0, outcome);
    check("store_outcome", 32'(outcome), OUT_RETIRED);
    // FENCE and a JAL to x0.
    run_instr(ONEHOT_FENCE_INDEX, 3'd0, 5'd3, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, outcome);
    run_instr(ONEHOT_JAL_INDEX, 3'd0, 5'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, outcome);

    // Illegal encodings.
    run_instr(ONEHOT_ITYPE_ALU_INDEX, 3'd0, 5'd1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, outcome);
    check("decerr_outcome", 32'(outcome), OUT_ILLEGAL);
    do_reset();
    run_instr(ONEHOT_ITYPE_ALU_INDEX, 3'd0, 5'd1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, outcome);
    run_instr(ONEHOT_LOAD_INDEX, 3'd7, 5'd1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, outcome);
    check("lf3_outcome", 32'(outcome), OUT_ILLEGAL);
    do_reset();

    // Fetch timeout, then ready on the last allowed cycle.
    run_instr(ONEHOT_ITYPE_ALU_INDEX, 3'd0, 5'd1, 1'b0, 1'b0, TIMEOUT, 0, 0, 0, 1'b0, outcome);
    check("timeout_outcome", 32'(outcome), OUT_TIMEOUT);
    do_reset();
    run_instr(ONEHOT_LOAD_INDEX, 3'd0, 5'd1, 1'b0, 1'b0, TIMEOUT - 1, TIMEOUT - 1,
              TIMEOUT - 1, TIMEOUT - 1, 1'b0, outcome);
    check("edge_outcome", 32'(outcome), OUT_RETIRED);

    // Debug halt, then reset in the middle of MEM_WAIT.
    run_instr(ONEHOT_DEBUG_INDEX, 3'd0, 5'd1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, outcome);
    check("halt_outcome", 32'(outcome), OUT_HALT);
    do_reset();
    run_instr(ONEHOT_LOAD_INDEX, 3'd0, 5'd4, 1'b0, 1'b0, 0, 0, 1, 2, 1'b1, outcome);
    check("mrst_outcome", 32'(outcome), OUT_RESET);
    do_reset();

    // Long legal run so retired_count wraps.
    for (int i = 0; i < 20; i++) begin
      cls = $urandom_range(0, ONEHOT_DEBUG_INDEX - 1);
      run_instr(cls, legal_f3(cls), 5'($urandom), 1'b0, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b0, outcome);
    end
    check("wrap_retired", 32'(retired_count), 20 % RMOD);

    // Fully random mix, occasionally trapping or halting.
    for (int i = 0; i < 60; i++) begin
      cls = $urandom_range(0, ONEHOT_DEBUG_INDEX);
      if (cls == ONEHOT_DEBUG_INDEX && $urandom_range(0, 3) != 0) cls = ONEHOT_RTYPE_ALU_INDEX;
      err = ($urandom_range(0, 19) == 0);
      fw  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, 3);
      rw  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, 3);
      mw  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, 3);
      mrw = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, 3);
      run_instr(cls, 3'($urandom), 5'($urandom), err, 1'($urandom), fw, rw, mw, mrw, 1'b0, outcome);
      if (outcome != OUT_RETIRED) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, writeback.
- Owns the instruction- and data-memory valid/ready handshakes.
- Consumes the one-hot opcode_selection and decoding_error from instruction_decode.
- Drives register-file, PC and writeback-mux enables, and counts retired instructions; traps on illegal encodings and bus timeouts; halts on the debug opcode.

Parameters:
RETIRE_COUNT_WIDTH, 32, width of retired_count (wraps modulo 2^width)
BUS_TIMEOUT_CYCLES, 255, wait cycles in any memory request/wait state before bus-timeout trap

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  instruction fetch request
imem_req_ready  input  1  fetch request accepted
imem_resp_valid  input  1  instruction word valid this cycle
instruction_latch_en  output  1  load instruction register (feeds instruction_decode)
opcode_selection  input  11  one-hot class from instruction_decode (ONEHOT_*_INDEX)
decoding_error  input  1  unsupported opcode
subfunction_3  input  3  funct3 of current instruction
destination_reg  input  5  rd of current instruction
branch_condition  input  1  ALU compare result for current branch
dmem_req_valid  output  1  data request
dmem_req_write  output  1  1 = store, 0 = load; valid only with dmem_req_valid
dmem_req_ready  input  1  data request accepted
dmem_resp_valid  input  1  load data valid / store complete
pc_write_en  output  1  update PC
pc_select  output  2  0 = pc+4, 1 = pc+immediate, 2 = rs1+immediate (JALR, bit0 cleared downstream)
reg_write_en  output  1  register-file write
writeback_select  output  2  0 = ALU, 1 = load data, 2 = pc+4
retired_count  output  RETIRE_COUNT_WIDTH  retired instructions
trap  output  1  sticky trap flag
trap_cause  output  2  0 = none, 1 = illegal instruction, 2 = bus timeout
halted  output  1  sticky halt flag (debug opcode)

Behaviour:
- Reset (synchronous, wins over everything): state = FETCH_REQ. All outputs 0; retired_count 0; wait counter 0; latched class 0.
- Reset mid-handshake drops valid the next cycle. Responses arriving after reset are ignored (valid only in FETCH_WAIT/MEM_WAIT).
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP, HALT.
- FETCH_REQ: imem_req_valid = 1. On valid && imem_req_ready, go to FETCH_WAIT.
- FETCH_WAIT: on imem_resp_valid, pulse instruction_latch_en for one cycle and go to DECODE. A response in the same cycle as request acceptance cannot occur; the earliest response is the next cycle.
- DECODE: latch opcode_selection, subfunction_3 and destination_reg into registers. Then, in priority order:
  - decoding_error, load funct3 in {3,6,7}, or store funct3 > 2 → TRAP, cause 1;
  - DEBUG → HALT;
  - otherwise → EXECUTE.
- EXECUTE: sample branch_condition into a register. LOAD/STORE → MEM_REQ; all other classes → WRITEBACK. FENCE is a no-op.
- MEM_REQ: dmem_req_valid = 1; dmem_req_write = latched STORE bit. On ready, go to MEM_WAIT.
- MEM_WAIT: on dmem_resp_valid, go to WRITEBACK.
- Wait counter: increments every cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT; clears on any state change. Reaching BUS_TIMEOUT_CYCLES → TRAP, cause 2, valid outputs dropped. A handshake completing in the same cycle the counter hits the limit wins over the timeout.
- WRITEBACK (one cycle), then go to FETCH_REQ:
  - pc_write_en = 1.
  - pc_select: JAL = 1; JALR = 2; BRANCH = 1 if sampled condition else 0; all other classes = 0.
  - reg_write_en = 1 for LUI, AUIPC, JAL, JALR, LOAD, ITYPE_ALU, RTYPE_ALU, forced to 0 when latched rd == 0.
  - writeback_select: LOAD = 1; JAL/JALR = 2; else 0.
  - retired_count += 1, wrapping to 0.
- TRAP and HALT are absorbing until reset. Flags are held, all enables and valids are 0, and retired_count is frozen. HALT does not count the debug instruction.
- All outputs decode from registered state and latched fields only; there is no combinational input-to-output path except the handshake exit conditions.
- Minimum latency: 5 cycles for a non-memory instruction with zero-wait memory; 7 cycles for load/store.

Decomposition:
- define.vh: state encodings (SEQ_STATE_*), trap-cause codes, pc_select and writeback_select codes; reuse the existing ONEHOT_*_INDEX constants.
- One sub-module, sequencer_wait_timer: parameterised wait counter with clear/enable/expired.

Test Plan:
- ADDI (ITYPE_ALU one-hot), rd = 5, zero-wait memory → instruction_latch_en at cycle 2, reg_write_en = 1 and writeback_select = 0 at cycle 4, retired_count = 1 at cycle 5.
- Taken BEQ (branch_condition = 1) then not-taken → pc_select 1 then 0; reg_write_en 0 both times; retired_count = 2.
- LW with dmem_req_ready delayed 3 cycles and response 2 cycles later → dmem_req_valid held 4 cycles with write = 0; writeback_select = 1; a SW variant shows write = 1 and reg_write_en = 0.
- decoding_error = 1 at DECODE, and separately load funct3 = 7 → trap = 1, trap_cause = 1, retired_count unchanged, no further imem_req_valid for 20 cycles.
- imem_req_ready held low with BUS_TIMEOUT_CYCLES = 8 → trap_cause = 2 after 8 cycles; repeat with ready asserted exactly on cycle 8 → no trap.
- DEBUG opcode → halted = 1; reset asserted mid-MEM_WAIT → next cycle FETCH_REQ, all outputs 0, and a late dmem_resp_valid is ignored.
